// File: rtl/fwd_hazard_unit_if.sv
// ID/EX/MEM hazard-unit signal bundle; master drives the pipeline side, slave is the hazard unit.
interface fwd_hazard_unit_if #(
   parameter int NUM_SRC = 2,
   parameter int AW      = 5,
   parameter int LAT_W   = 4,
   parameter int MAX_MC  = 4
);
   localparam int CW   = $clog2(MAX_MC + 1);
   localparam int NREG = 1 << AW;

   logic                    id_valid;
   logic                    id_flush;
   logic [NUM_SRC*AW-1:0]   id_rs_addr;
   logic [NUM_SRC-1:0]      id_rs_used;
   logic [AW-1:0]           id_rd_addr;
   logic                    id_reg_write;
   logic [LAT_W-1:0]        id_lat;
   logic [AW-1:0]           ex_rd_addr;
   logic                    ex_reg_write;
   logic                    ex_mem_read;
   logic [AW-1:0]           mem_rd_addr;
   logic                    mem_reg_write;
   logic                    id_stall;
   logic [NUM_SRC*2-1:0]    ex_fwd_sel;
   logic [CW-1:0]           mc_count;
   logic [NREG-1:0]         sb_busy;

   modport master (
      output id_valid, id_flush, id_rs_addr, id_rs_used, id_rd_addr, id_reg_write, id_lat,
             ex_rd_addr, ex_reg_write, ex_mem_read, mem_rd_addr, mem_reg_write,
      input  id_stall, ex_fwd_sel, mc_count, sb_busy
   );

   modport slave (
      input  id_valid, id_flush, id_rs_addr, id_rs_used, id_rd_addr, id_reg_write, id_lat,
             ex_rd_addr, ex_reg_write, ex_mem_read, mem_rd_addr, mem_reg_write,
      output id_stall, ex_fwd_sel, mc_count, sb_busy
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forward select, load-use/scoreboard stall and multi-cycle op tracking for the ID stage.
// id_stall is combinational; ex_fwd_sel, sb_busy and mc_count update on each rising edge.
module fwd_hazard_unit #(
   parameter int NUM_SRC = 2,
   parameter int AW      = 5,
   parameter int LAT_W   = 4,
   parameter int MAX_MC  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   fwd_hazard_unit_if.slave bus
);
   localparam int CW   = $clog2(MAX_MC + 1);
   localparam int NREG = 1 << AW;

   logic [LAT_W-1:0]     cnt_q [NREG];
   logic [LAT_W-1:0]     cnt_d [NREG];
   logic [NUM_SRC*2-1:0] fwd_q, fwd_d;
   logic [CW-1:0]        mc_q, mc_d, n_done;
   logic [NREG-1:0]      busy;
   logic [NUM_SRC-1:0]   m_ex, m_mem, rs_busy;
   logic                 load_use, raw_busy, waw_busy, mc_full;
   logic                 stall, advance, issue, rd_nz;

   always_comb begin
      busy = '0;
      for (int r = 0; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      logic [AW-1:0] rs_a;
      logic          live;
      assign rs_a       = bus.id_rs_addr[k*AW +: AW];
      assign live       = bus.id_rs_used[k] && (rs_a != '0);
      assign m_ex[k]    = live && bus.ex_reg_write  && (rs_a == bus.ex_rd_addr);
      assign m_mem[k]   = live && bus.mem_reg_write && (rs_a == bus.mem_rd_addr);
      assign rs_busy[k] = live && busy[rs_a];
      assign fwd_d[k*2 +: 2] = !advance ? 2'b00 :
                               m_ex[k]  ? 2'b10 :
                               m_mem[k] ? 2'b01 : 2'b00;
   end

   assign rd_nz    = (bus.id_rd_addr != '0);
   assign load_use = bus.ex_mem_read && (|m_ex);
   assign raw_busy = |rs_busy;
   assign waw_busy = bus.id_reg_write && rd_nz && busy[bus.id_rd_addr];
   assign mc_full  = (bus.id_lat != '0) && bus.id_reg_write && rd_nz && (mc_q == CW'(MAX_MC));
   assign stall    = rst_n && bus.id_valid && !bus.id_flush &&
                     (load_use || raw_busy || waw_busy || mc_full);
   assign advance  = bus.id_valid && !bus.id_flush && !stall;
   assign issue    = advance && bus.id_reg_write && rd_nz && (bus.id_lat != '0);

   // An issuing destination is never busy (waw check), so issue and decrement never collide.
   always_comb begin
      n_done = '0;
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
         if (cnt_q[r] == LAT_W'(1)) n_done = n_done + 1'b1;
         if (issue && (bus.id_rd_addr == AW'(r))) cnt_d[r] = bus.id_lat;
         if (r == 0) cnt_d[r] = '0;
      end
      mc_d = mc_q + CW'(issue) - n_done;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         fwd_q <= '0;
         mc_q  <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         fwd_q <= fwd_d;
         mc_q  <= mc_d;
      end
   end

   assign bus.id_stall   = stall;
   assign bus.ex_fwd_sel = fwd_q;
   assign bus.mc_count   = mc_q;
   assign bus.sb_busy    = busy;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table-driven forwarding/stall vectors plus multi-cycle scoreboard sequences for fwd_hazard_unit.
module tb_fwd_hazard_unit;
   localparam int NUM_SRC = 2;
   localparam int AW      = 5;
   localparam int LAT_W   = 4;
   localparam int MAX_MC  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .AW(AW), .LAT_W(LAT_W), .MAX_MC(MAX_MC)) bus ();
   fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .LAT_W(LAT_W), .MAX_MC(MAX_MC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic       valid, flush;
      logic [4:0] rs0, rs1;
      logic [1:0] used;
      logic [4:0] ex_rd;
      logic       ex_we, ex_mr;
      logic [4:0] mem_rd;
      logic       mem_we;
      logic       stall;
      logic [3:0] fwd;
   } vec_t;
   vec_t tv[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic id(input logic v, input logic f, input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic [1:0] used, input logic [4:0] rd, input logic we,
                     input logic [3:0] lat);
      bus.id_valid     = v;
      bus.id_flush     = f;
      bus.id_rs_addr   = {rs1, rs0};
      bus.id_rs_used   = used;
      bus.id_rd_addr   = rd;
      bus.id_reg_write = we;
      bus.id_lat       = lat;
   endtask

   task automatic pipe(input logic [4:0] ex_rd, input logic ex_we, input logic ex_mr,
                       input logic [4:0] mem_rd, input logic mem_we);
      bus.ex_rd_addr    = ex_rd;
      bus.ex_reg_write  = ex_we;
      bus.ex_mem_read   = ex_mr;
      bus.mem_rd_addr   = mem_rd;
      bus.mem_reg_write = mem_we;
   endtask

   // Check the combinational stall, queue the select expected after the edge, then check it.
   task automatic cycle(input string name, input logic exp_stall, input logic [3:0] exp_fwd);
      logic [3:0] e;
      #1;
      chk({name, " stall"}, 32'(bus.id_stall), 32'(exp_stall));
      exp_q.push_back(exp_fwd);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({name, " fwd"}, 32'(bus.ex_fwd_sel), 32'(e));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   initial begin
      tv[0]  = '{1, 0, 5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 4'b0010};
      tv[1]  = '{1, 0, 0, 5, 2'b10, 0, 0, 0, 5, 1, 0, 4'b0100};
      tv[2]  = '{1, 0, 5, 0, 2'b01, 5, 1, 0, 5, 1, 0, 4'b0010};
      tv[3]  = '{1, 0, 0, 7, 2'b11, 7, 1, 1, 0, 0, 1, 4'b0000};
      tv[4]  = '{1, 0, 0, 7, 2'b10, 0, 0, 0, 7, 1, 0, 4'b0100};
      tv[5]  = '{1, 0, 0, 0, 2'b11, 0, 1, 0, 0, 1, 0, 4'b0000};
      tv[6]  = '{1, 0, 3, 3, 2'b00, 3, 1, 0, 3, 1, 0, 4'b0000};
      tv[7]  = '{1, 1, 3, 0, 2'b01, 3, 1, 1, 0, 0, 0, 4'b0000};
      tv[8]  = '{0, 0, 3, 0, 2'b01, 3, 1, 0, 0, 0, 0, 4'b0000};
      tv[9]  = '{1, 0, 4, 0, 2'b01, 4, 0, 0, 0, 0, 0, 4'b0000};
      tv[10] = '{1, 0, 2, 9, 2'b11, 9, 1, 0, 2, 1, 0, 4'b1001};
      tv[11] = '{1, 0, 6, 7, 2'b11, 7, 1, 1, 6, 1, 1, 4'b0000};

      // Reset with a load-use hazard present: stall must be held low.
      id(1, 0, 7, 0, 2'b01, 0, 0, 0);
      pipe(7, 1, 1, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst stall", 32'(bus.id_stall), 0);
      chk("rst fwd", 32'(bus.ex_fwd_sel), 0);
      chk("rst mc", 32'(bus.mc_count), 0);
      chk("rst busy", bus.sb_busy, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         id(tv[i].valid, tv[i].flush, tv[i].rs0, tv[i].rs1, tv[i].used, 0, 0, 0);
         pipe(tv[i].ex_rd, tv[i].ex_we, tv[i].ex_mr, tv[i].mem_rd, tv[i].mem_we);
         cycle($sformatf("vec%0d", i), tv[i].stall, tv[i].fwd);
      end

      // mul x9 lat 3, then a reader of x9 stalls three cycles.
      pipe(0, 0, 0, 0, 0);
      id(1, 0, 0, 0, 2'b00, 9, 1, 3);
      cycle("mul issue", 0, 0);
      chk("mul busy9", 32'(bus.sb_busy[9]), 1);
      chk("mul mc1", 32'(bus.mc_count), 1);
      id(1, 0, 9, 0, 2'b01, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle($sformatf("mul wait%0d", i), 1, 0);
      chk("mul mc0", 32'(bus.mc_count), 0);
      cycle("mul go", 0, 0);

      // Flush does not cancel an issued op.
      id(1, 0, 0, 0, 2'b00, 8, 1, 2);
      cycle("fl issue", 0, 0);
      id(1, 1, 8, 0, 2'b01, 0, 0, 0);
      pipe(8, 1, 1, 0, 0);
      cycle("fl flush", 0, 0);
      chk("fl busy8", 32'(bus.sb_busy[8]), 1);
      pipe(0, 0, 0, 0, 0);
      id(0, 0, 0, 0, 2'b00, 0, 0, 0);
      cycle("fl idle", 0, 0);
      chk("fl clear8", 32'(bus.sb_busy[8]), 0);
      chk("fl mc0", 32'(bus.mc_count), 0);

      // Fill MAX_MC slots, fifth op waits for the first completion.
      for (int i = 1; i <= 4; i++) begin
         id(1, 0, 0, 0, 2'b00, 5'(i), 1, 10);
         cycle($sformatf("mc issue%0d", i), 0, 0);
      end
      chk("mc full4", 32'(bus.mc_count), 4);
      id(1, 0, 0, 0, 2'b00, 6, 1, 10);
      for (int i = 0; i < 7; i++) cycle($sformatf("mc stall%0d", i), 1, 0);
      chk("mc drop3", 32'(bus.mc_count), 3);
      chk("mc x1 free", 32'(bus.sb_busy[1]), 0);
      cycle("mc x6 issue", 0, 0);
      chk("mc after", 32'(bus.mc_count), 3);
      chk("mc busy6", 32'(bus.sb_busy[6]), 1);
      chk("mc x2 free", 32'(bus.sb_busy[2]), 0);

      // Reset mid-operation discards the scoreboard.
      id(0, 0, 0, 0, 2'b00, 0, 0, 0);
      rst_n = 1'b0;
      cycle("r clear", 0, 0);
      rst_n = 1'b1;
      id(1, 0, 0, 0, 2'b00, 3, 1, 5);
      cycle("r issue3", 0, 0);
      chk("r busy3", 32'(bus.sb_busy[3]), 1);
      id(1, 0, 3, 0, 2'b01, 0, 0, 0);
      rst_n = 1'b0;
      cycle("r mid", 0, 0);
      rst_n = 1'b1;
      chk("r busy0", bus.sb_busy, 0);
      chk("r mc0", 32'(bus.mc_count), 0);
      cycle("r read3", 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
